// File: rtl/mul_seq_ctrl.sv
// ---------------------------------------------------------------------------
// mul_seq_ctrl
//
// Control FSM for a shift-free sequential multiplier.  It loads A, then B,
// from a shared data bus and clears the product.  It then adds A into P
// once per cycle while decrementing B, until B reaches zero.  The product
// is held with done=1 until the requester acknowledges it.
//
// Optional feature (macro MUL_ITER_LIMIT_EN):
//   When defined, the FSM counts accumulate pulses and aborts into ERR on
//   the edge that takes the MAX_ITER-th pulse.  If eqz is set in that same
//   cycle, it goes to DONE instead.  ERR is held until ack.
//   When undefined, there is no counter and no ERR state, and err is
//   tied to 0.
//
// Parameters:
//   MAX_ITER  maximum accumulate pulses before abort (MUL_ITER_LIMIT_EN only)
//   CNT_W     width of the iteration counter; MAX_ITER must fit in CNT_W bits
//
// Ports:
//   clk    in   single clock, rising edge
//   rst    in   asynchronous, active-high reset
//   start  in   request a multiplication (sampled only in IDLE)
//   ack    in   acknowledge done/err (sampled only in DONE/ERR)
//   eqz    in   datapath flag: B register == 0
//   lda    out  load A from bus              (LOAD_A)
//   ldb    out  load B from bus              (LOAD_B)
//   clrp   out  clear product                (LOAD_B)
//   ldp    out  P <= P + A                   (ACCUM and B != 0)
//   decb   out  B <= B - 1                   (ACCUM and B != 0)
//   busy   out  operation in progress        (LOAD_A, LOAD_B, ACCUM)
//   done   out  product valid, held until ack
//   err    out  iteration limit exceeded, held until ack
// ---------------------------------------------------------------------------
module mul_seq_ctrl #(
   parameter int MAX_ITER = 255,
   parameter int CNT_W    = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic ack,
   input  logic eqz,
   output logic lda,
   output logic ldb,
   output logic clrp,
   output logic ldp,
   output logic decb,
   output logic busy,
   output logic done,
   output logic err
);

   // State encoding.  Codes 3'd6 and 3'd7 are never used.  Code 3'd5 is
   // used only when the limit feature is built in.  Any unused code
   // decodes to all-zero outputs and returns to IDLE on the next edge.
   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LOAD_A = 3'd1;
   localparam logic [2:0] S_LOAD_B = 3'd2;
   localparam logic [2:0] S_ACCUM  = 3'd3;
   localparam logic [2:0] S_DONE   = 3'd4;
`ifdef MUL_ITER_LIMIT_EN
   localparam logic [2:0] S_ERR    = 3'd5;
`endif

   logic [2:0] state;
   logic [2:0] state_next;

   // An accumulate step happens only while B is still non-zero.  Once eqz
   // rises, the ACCUM cycle exists purely to hand over to DONE.
   logic accum_step;
   assign accum_step = (state == S_ACCUM) && !eqz;

`ifdef MUL_ITER_LIMIT_EN
   // The counter holds the number of pulses already taken.  When it equals
   // MAX_ITER-1 and another pulse is being taken, that pulse is the
   // MAX_ITER-th one, so this edge is the abort edge.
   localparam logic [CNT_W-1:0] LAST_PULSE = CNT_W'(MAX_ITER - 1);

   logic [CNT_W-1:0] iter_cnt;
   logic             limit_hit;

   assign limit_hit = accum_step && (iter_cnt == LAST_PULSE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         iter_cnt <= '0;
      end else if (state == S_LOAD_B) begin
         iter_cnt <= '0;
      end else if (accum_step) begin
         iter_cnt <= iter_cnt + 1'b1;
      end
   end
`else
   // Without the limit feature the size parameters have no effect.  They
   // are folded into a named sink so the build stays warning-free.
   logic cfg_unused;
   assign cfg_unused = (MAX_ITER > 0) ^ (CNT_W > 0);
`endif

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic.
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_next = S_LOAD_A;
            end
         end
         S_LOAD_A: begin
            state_next = S_LOAD_B;
         end
         S_LOAD_B: begin
            state_next = S_ACCUM;
         end
         S_ACCUM: begin
            // eqz wins over the limit when both are present.
            if (eqz) begin
               state_next = S_DONE;
`ifdef MUL_ITER_LIMIT_EN
            end else if (limit_hit) begin
               state_next = S_ERR;
`endif
            end
         end
         S_DONE: begin
            // A start arriving together with ack is dropped.  It is seen
            // only once the FSM is back in IDLE.
            if (ack) begin
               state_next = S_IDLE;
            end
         end
`ifdef MUL_ITER_LIMIT_EN
         S_ERR: begin
            if (ack) begin
               state_next = S_IDLE;
            end
         end
`endif
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // Output decode.  All outputs are Moore except ldp/decb, which are gated
   // by eqz so that no accumulate is issued once B is zero.
   always_comb begin
      lda  = 1'b0;
      ldb  = 1'b0;
      clrp = 1'b0;
      ldp  = 1'b0;
      decb = 1'b0;
      busy = 1'b0;
      done = 1'b0;
      err  = 1'b0;
      case (state)
         S_LOAD_A: begin
            lda  = 1'b1;
            busy = 1'b1;
         end
         S_LOAD_B: begin
            ldb  = 1'b1;
            clrp = 1'b1;
            busy = 1'b1;
         end
         S_ACCUM: begin
            ldp  = accum_step;
            decb = accum_step;
            busy = 1'b1;
         end
         S_DONE: begin
            done = 1'b1;
         end
`ifdef MUL_ITER_LIMIT_EN
         S_ERR: begin
            err = 1'b1;
         end
`endif
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mul_seq_ctrl
//
// Bench for mul_seq_ctrl.  It contains a small A/B/P datapath driven by the
// controller, and a transaction-level model.  The model records the cycle
// in which a start was accepted and the operand B.  Each cycle's expected
// outputs follow from the offset k since that cycle:
//   k=0 LOAD_A, k=1 LOAD_B, k=2..B+1 accumulate, k=B+2 last ACCUM cycle,
//   k>=B+3 done.
// With the limit feature, an operand with B >= MAX_ITER takes MAX_ITER
// pulses and reports err from k=MAX_ITER+2.
// ---------------------------------------------------------------------------
module tb_mul_seq_ctrl;

`ifdef MUL_ITER_LIMIT_EN
   localparam int TB_MAX = 4;
`else
   localparam int TB_MAX = 255;
`endif

   logic clk;
   logic rst;
   logic start;
   logic ack;
   logic eqz;
   logic lda, ldb, clrp, ldp, decb, busy, done, err;

   // Datapath seen by the controller.
   logic [7:0]  opa, opb, bus;
   logic [7:0]  reg_a, reg_b;
   logic [15:0] reg_p;

   int checks = 0;
   int errors = 0;

   // Transaction-level model state.
   bit m_active = 1'b0;
   int m_s      = 0;
   int cyc      = 0;
   int ma       = 0;
   int mn       = 0;

   mul_seq_ctrl #(
      .MAX_ITER (TB_MAX),
      .CNT_W    (8)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .ack   (ack),
      .eqz   (eqz),
      .lda   (lda),
      .ldb   (ldb),
      .clrp  (clrp),
      .ldp   (ldp),
      .decb  (decb),
      .busy  (busy),
      .done  (done),
      .err   (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign bus = lda ? opa : opb;
   assign eqz = (reg_b == 8'd0);

   initial begin
      reg_a = 8'd0;
      reg_b = 8'd0;
      reg_p = 16'd0;
   end

   always @(posedge clk) begin
      if (lda)  reg_a <= bus;
      if (ldb)  reg_b <= bus;
      if (decb) reg_b <= reg_b - 8'd1;
      if (clrp) reg_p <= 16'd0;
      if (ldp)  reg_p <= reg_p + {8'd0, reg_a};
   end

   function automatic bit limited(input int n);
`ifdef MUL_ITER_LIMIT_EN
      return (n >= TB_MAX);
`else
      return 1'b0;
`endif
   endfunction

   function automatic int end_k(input int n);
      return limited(n) ? (TB_MAX + 2) : (n + 3);
   endfunction

   // Expected {lda,ldb,clrp,ldp,decb,busy,done,err}.
   function automatic logic [7:0] model_out();
      int k;
      int last_pulse;
      logic [7:0] v;
      v = 8'd0;
      if (rst || !m_active) return v;
      k = cyc - m_s;
      last_pulse = limited(mn) ? (TB_MAX + 1) : (mn + 1);
      if (k == 0) v[7] = 1'b1;
      if (k == 1) begin
         v[6] = 1'b1;
         v[5] = 1'b1;
      end
      if (k >= 2 && k <= last_pulse) begin
         v[4] = 1'b1;
         v[3] = 1'b1;
      end
      if (k < end_k(mn)) v[2] = 1'b1;
      else if (limited(mn)) v[0] = 1'b1;
      else v[1] = 1'b1;
      return v;
   endfunction

   // Model update: one step per clock edge; reset drops any transaction.
   initial begin
      int k_old;
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            m_active = 1'b0;
            if (clk) cyc = cyc + 1;
         end else begin
            k_old = cyc - m_s;
            cyc = cyc + 1;
            if (!m_active) begin
               if (start) begin
                  m_active = 1'b1;
                  m_s = cyc;
                  ma = int'(opa);
                  mn = int'(opb);
               end
            end else if (k_old >= end_k(mn) && ack) begin
               m_active = 1'b0;
            end
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Compare process: every cycle, on the falling edge.
   initial begin
      logic [7:0] exp_v;
      forever begin
         @(negedge clk);
         exp_v = model_out();
         chk("outputs", int'({lda, ldb, clrp, ldp, decb, busy, done, err}), int'(exp_v));
         if (exp_v[1]) chk("product", int'(reg_p), ma * mn);
      end
   end

   // Run one operation.  Returns cycles from the start edge to done/err,
   // the number of ldp pulses seen, and the product register at completion.
   task automatic do_op(input int a, input int b, input bit mid_start,
                        input bit done_start, input bit ack_start,
                        input int ack_delay,
                        output int lat, output int pulses, output int prod,
                        output bit fin_done, output bit fin_err);
      opa = 8'(a);
      opb = 8'(b);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      lat = 0;
      pulses = 0;
      while (!(done || err) && lat < 600) begin
         if (ldp) pulses++;
         @(posedge clk);
         #1;
         lat++;
         if (mid_start) start = (lat == 3);
      end
      start = 1'b0;
      if (lat >= 600) chk("completion_timeout", lat, -1);
      prod = int'(reg_p);
      fin_done = done;
      fin_err = err;
      if (done_start) begin
         start = 1'b1;
         @(posedge clk);
         #1;
         start = 1'b0;
      end
      repeat (ack_delay) @(posedge clk);
      #1;
      ack = 1'b1;
      start = ack_start;
      @(posedge clk);
      #1;
      ack = 1'b0;
      start = 1'b0;
   endtask

   initial begin
      int lat, pulses, prod;
      bit fd, fe;
      int a, b;
      rst = 1'b1;
      start = 1'b0;
      ack = 1'b0;
      opa = 8'd0;
      opb = 8'd0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_outputs", int'({lda, ldb, clrp, ldp, decb, busy, done, err}), 0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // A=5, B=3.
      do_op(5, 3, 1'b0, 1'b0, 1'b0, 0, lat, pulses, prod, fd, fe);
      chk("a5b3_latency", lat, 6);
      chk("a5b3_pulses", pulses, 3);
      chk("a5b3_product", prod, 15);
      chk("a5b3_done", int'(fd), 1);

      // B=0.
      do_op(9, 0, 1'b0, 1'b0, 1'b0, 1, lat, pulses, prod, fd, fe);
      chk("b0_latency", lat, 3);
      chk("b0_pulses", pulses, 0);
      chk("b0_product", prod, 0);

      // start during ACCUM and in DONE without ack; ack together with start.
      do_op(6, 2, 1'b1, 1'b1, 1'b1, 0, lat, pulses, prod, fd, fe);
      chk("restart_product", prod, 12);
      chk("ackstart_idle", int'({lda, busy, done}), 0);

      // start on the cycle right after ack+start.
      do_op(11, 1, 1'b0, 1'b0, 1'b0, 0, lat, pulses, prod, fd, fe);
      chk("after_ackstart_product", prod, 11);
      chk("after_ackstart_latency", lat, 4);

      // Reset in the middle of ACCUM, between edges.
      opa = 8'd9;
      opb = 8'd20;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("midreset_outputs", int'({lda, ldb, clrp, ldp, decb, busy, done, err}), 0);
      start = 1'b1;
      @(posedge clk);
      #1;
      chk("reset_start_ignored", int'({lda, busy}), 0);
      start = 1'b0;
      @(posedge clk);
      #2;
      rst = 1'b0;
      @(posedge clk);
      #1;
      do_op(7, 2, 1'b0, 1'b0, 1'b0, 0, lat, pulses, prod, fd, fe);
      chk("post_reset_product", prod, 14);
      chk("post_reset_latency", lat, 5);

`ifdef MUL_ITER_LIMIT_EN
      // Limit abort: MAX_ITER=4, B=10.
      do_op(3, 10, 1'b0, 1'b0, 1'b0, 1, lat, pulses, prod, fd, fe);
      chk("limit_pulses", pulses, 4);
      chk("limit_err", int'(fe), 1);
      chk("limit_done", int'(fd), 0);
      chk("limit_latency", lat, 6);
      chk("limit_back_idle", int'({busy, done, err}), 0);
`endif

      // Randomized operations.
      for (int i = 0; i < 40; i++) begin
         a = int'($urandom_range(255, 0));
`ifdef MUL_ITER_LIMIT_EN
         b = int'($urandom_range(10, 0));
`else
         b = int'($urandom_range(15, 0));
`endif
         do_op(a, b, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
               1'($urandom_range(1, 0)), int'($urandom_range(2, 0)),
               lat, pulses, prod, fd, fe);
         chk("rand_latency", lat, limited(b) ? TB_MAX + 2 : b + 3);
         chk("rand_pulses", pulses, limited(b) ? TB_MAX : b);
         if (limited(b)) chk("rand_err", int'({fd, fe}), 1);
         else chk("rand_product", prod, a * b);
      end

      repeat (2) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/mul_seq_ctrl.md
MUL_SEQ_CTRL -- requirements
Module: mul_seq_ctrl

Interface
REQ-001 SHALL provide parameter: MAX_ITER, 255, maximum accumulate cycles before abort (used only with MUL_ITER_LIMIT_EN).
REQ-002 SHALL provide parameter: CNT_W, 8, width of iteration counter; MAX_ITER SHALL fit in CNT_W bits.
REQ-003 SHALL provide port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL provide port: rst  input  1  reset; asynchronous, active-high.
REQ-005 SHALL provide port: start  input  1  request a multiplication; sampled only in IDLE.
REQ-006 SHALL provide port: ack  input  1  requester acknowledges done/err; sampled only in DONE/ERR.
REQ-007 SHALL provide port: eqz  input  1  datapath flag, B register == 0, combinational from B.
REQ-008 SHALL provide port: lda, ldb  output  1 each  load A / load B from shared data bus.
REQ-009 SHALL provide port: clrp, ldp  output  1 each  clear product / load product (P <= P + A).
REQ-010 SHALL provide port: decb  output  1  decrement B.
REQ-011 SHALL provide port: busy  output  1  operation in progress.
REQ-012 SHALL provide port: done  output  1  product valid, held until ack.
REQ-013 SHALL provide port: err  output  1  iteration limit exceeded, held until ack; constant 0 without MUL_ITER_LIMIT_EN.

Function
REQ-014 SHALL implement states IDLE, LOAD_A, LOAD_B, ACCUM, DONE, and ERR (ERR present only with MUL_ITER_LIMIT_EN).
REQ-015 SHALL transition IDLE->LOAD_A when start=1, else remain in IDLE; start in any other state SHALL be ignored.
REQ-016 SHALL transition LOAD_A->LOAD_B and LOAD_B->ACCUM unconditionally.
REQ-017 SHALL transition ACCUM->DONE when eqz=1, else remain in ACCUM.
REQ-018 SHALL transition DONE->IDLE (and ERR->IDLE) when ack=1; start seen with ack in the same cycle SHALL NOT begin a new operation.
REQ-019 SHALL decode lda=1 only in LOAD_A; ldb=1 and clrp=1 only in LOAD_B (Moore).
REQ-020 SHALL drive ldp=decb=1 only when state==ACCUM and eqz==0 (Mealy-gated), so no accumulate occurs once B==0.
REQ-021 SHALL drive busy=1 in LOAD_A, LOAD_B, ACCUM; done=1 only in DONE; err=1 only in ERR.
REQ-022 SHALL assert lda, ldb, clrp, ldp, decb mutually exclusive with respect to {lda}, {ldb,clrp}, {ldp,decb} groups.
REQ-023 SHALL complete for operand B=n with exactly n ldp pulses and done asserted n+3 cycles after the edge that samples start.
REQ-024 SHALL handle B=0: ACCUM lasts one cycle with ldp=0, done after 3 cycles, product 0.
REQ-025 SHALL treat an illegal state encoding as IDLE on the next edge with all outputs 0.

Reset
REQ-026 SHALL, on rst=1, immediately enter IDLE regardless of clock, including mid-operation.
REQ-027 SHALL drive lda, ldb, clrp, ldp, decb, busy, done, err to 0 while rst=1, and clear the iteration counter.
REQ-028 SHALL ignore start until the first rising edge after rst deasserts.

Configuration
REQ-029 SHALL, with macro MUL_ITER_LIMIT_EN defined, count ldp pulses in ACCUM (counter cleared in LOAD_B) and transition ACCUM->ERR on the edge where the MAX_ITER-th pulse is taken without eqz following.
REQ-030 SHALL, with MUL_ITER_LIMIT_EN defined, give eqz priority over the limit when both occur in the same cycle (go to DONE).
REQ-031 SHALL, without MUL_ITER_LIMIT_EN, omit counter and ERR state, tie err to 0, and never abort.

Verification
REQ-032 SHALL cover: start pulse, A=5, B=3 -> lda, ldb+clrp one cycle each, 3 ldp/decb pulses, done at cycle 6, P=15.
REQ-033 SHALL cover: B=0 -> no ldp pulse, done at cycle 3, P=0.
REQ-034 SHALL cover: start re-asserted during ACCUM and in DONE without ack -> no lda pulse, operation unaffected.
REQ-035 SHALL cover: rst asserted mid-ACCUM between edges -> all outputs 0 before next edge, IDLE; new start after release yields correct product.
REQ-036 SHALL cover: MUL_ITER_LIMIT_EN, MAX_ITER=4, B=10 -> exactly 4 ldp pulses, err=1, done=0, ack returns to IDLE.
REQ-037 SHALL cover: ack and start asserted together in DONE -> IDLE next cycle, no lda; start next cycle -> LOAD_A.
